// File: rtl/m3_sopc_sw_debounce.sv
// Per-bit 2-flop synchronizer plus counter debouncer for the board switches.
// Emits registered one-cycle rise/fall/change pulses whenever the debounced level flips.
module m3_sopc_sw_debounce #(
  parameter int unsigned      WIDTH         = 10,
  parameter int unsigned      CNT_W         = 16,
  parameter int unsigned      STABLE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_d, rise_d, fall_d;

  // Each bit is idle when s2 matches sw_stable and counting otherwise; a match clears the count.
  always_comb begin
    stable_d = sw_stable;
    rise_d   = '0;
    fall_d   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != sw_stable[i]) begin
        if (cnt_q[i] == CntLast) begin
          stable_d[i] = s2_q[i];
          rise_d[i]   = s2_q[i];
          fall_d[i]   = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= RESET_VALUE;
      s2_q       <= RESET_VALUE;
      sw_stable  <= RESET_VALUE;
      sw_rise    <= '0;
      sw_fall    <= '0;
      sw_changed <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q       <= sw_raw;
      s2_q       <= s1_q;
      sw_stable  <= stable_d;
      sw_rise    <= rise_d;
      sw_fall    <= fall_d;
      sw_changed <= |(rise_d | fall_d);
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_m3_sopc_sw_debounce.sv
// Directed bench for m3_sopc_sw_debounce with STABLE_CYCLES=4, WIDTH=10.
// Inputs change just after a rising edge; outputs are sampled 1 ns after the next edge.
module tb_m3_sopc_sw_debounce;

  localparam int unsigned W = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_stable, sw_rise, sw_fall;
  logic         sw_changed;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic         rst;
    logic [W-1:0] raw;
    logic [W-1:0] stable;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         chg;
  } vec_t;

  vec_t vecs[$];

  m3_sopc_sw_debounce #(
    .WIDTH        (W),
    .CNT_W        (16),
    .STABLE_CYCLES(4),
    .RESET_VALUE  ('0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_outs(input string tag, input logic [W-1:0] st, input logic [W-1:0] ri,
                            input logic [W-1:0] fa, input logic ch);
    check({tag, " stable"}, 32'(sw_stable), 32'(st));
    check({tag, " rise"}, 32'(sw_rise), 32'(ri));
    check({tag, " fall"}, 32'(sw_fall), 32'(fa));
    check({tag, " changed"}, 32'(sw_changed), 32'(ch));
  endtask

  task automatic add_row(input logic rst, input logic [W-1:0] raw, input logic [W-1:0] st,
                         input logic [W-1:0] ri, input logic [W-1:0] fa, input logic ch);
    vec_t v;
    v.rst = rst; v.raw = raw; v.stable = st; v.rise = ri; v.fall = fa; v.chg = ch;
    vecs.push_back(v);
  endtask

  // Raw moves to 'raw' before edge k; the new level and pulse appear after edge k+5.
  task automatic add_change(input logic [W-1:0] raw, input logic [W-1:0] old_v,
                            input logic [W-1:0] new_v);
    for (int i = 0; i < 5; i++) add_row(1'b0, raw, old_v, '0, '0, 1'b0);
    add_row(1'b0, raw, new_v, new_v & ~old_v, old_v & ~new_v, 1'b1);
    add_row(1'b0, raw, new_v, '0, '0, 1'b0);
  endtask

  initial begin
    int rise_cnt;
    int rise_at;

    // Reset held 3 clocks with all switches high.
    reset  = 1'b1;
    sw_raw = 10'h3FF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs($sformatf("reset%0d", i), '0, '0, '0, 1'b0);
    end
    reset = 1'b0;
    tick();
    check_outs("post_reset", '0, '0, '0, 1'b0);
    // The brief 3FF in s2 is far too short to debounce.
    sw_raw = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_outs($sformatf("settle%0d", i), '0, '0, '0, 1'b0);
    end

    // Vector table
    add_change(10'h001, 10'h000, 10'h001);
    add_change(10'h201, 10'h001, 10'h201);
    add_change(10'h000, 10'h201, 10'h000);
    // bit3 high in s2 for three clocks only: counter reaches 3 but never terminal
    for (int i = 0; i < 3; i++) add_row(1'b0, 10'h008, '0, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) add_row(1'b0, 10'h000, '0, '0, '0, 1'b0);
    // A later real change needs the full count again
    add_change(10'h008, 10'h000, 10'h008);
    add_change(10'h000, 10'h008, 10'h000);
    // bit5 reset mid-count (cnt=2 after the 4th row), then a full debounce after release
    for (int i = 0; i < 4; i++) add_row(1'b0, 10'h020, '0, '0, '0, 1'b0);
    add_row(1'b1, 10'h020, '0, '0, '0, 1'b0);
    add_change(10'h020, 10'h000, 10'h020);
    add_change(10'h000, 10'h020, 10'h000);

    foreach (vecs[i]) begin
      reset  = vecs[i].rst;
      sw_raw = vecs[i].raw;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].stable, vecs[i].rise, vecs[i].fall,
                 vecs[i].chg);
    end
    reset = 1'b0;

    // Chatter on bit1 for 20 clocks, then hold high.
    for (int j = 0; j < 20; j++) begin
      sw_raw = (j % 2 == 0) ? 10'h002 : 10'h000;
      tick();
      check($sformatf("chatter%0d stable", j), 32'(sw_stable), 32'h0);
      check($sformatf("chatter%0d changed", j), 32'(sw_changed), 32'h0);
    end
    sw_raw   = 10'h002;
    rise_cnt = 0;
    rise_at  = -1;
    for (int t = 0; t < 9; t++) begin
      tick();
      if (sw_rise != '0) begin
        rise_cnt++;
        rise_at = t;
        check("chatter rise value", 32'(sw_rise), 32'h002);
      end
    end
    check("chatter rise count", 32'(rise_cnt), 32'd1);
    check("chatter rise edge", 32'(rise_at), 32'd5);
    check("chatter final stable", 32'(sw_stable), 32'h002);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
